// File: rtl/macc_acc.sv
// Pipelined NUM_INPUTS-lane dot-product MACC with multi-beat accumulation.
// Optional MACC_RELU_EN clamps negative final results to zero at the output only.
module macc_acc #(
    parameter int NUM_INPUTS = 9,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH*NUM_INPUTS-1:0] i_data_a,
    input  logic [DATA_WIDTH*NUM_INPUTS-1:0] i_data_b,
    input  logic                             i_valid,
    input  logic                             i_last,
    input  logic                             i_signed,
    output logic [ACC_WIDTH-1:0]             o_data,
    output logic                             o_valid
);

    localparam int LAYERS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
    localparam int PROD_W = 2*DATA_WIDTH + 1;
    localparam int TREE_W = PROD_W + LAYERS;

    function automatic int lane_count(input int layer);
        return (NUM_INPUTS + (1 << layer) - 1) >> layer;
    endfunction

    // Keeps array indices in range for node slots that are never used.
    function automatic int clamp_idx(input int idx);
        return (idx < NUM_INPUTS) ? idx : 0;
    endfunction

    function automatic logic signed [PROD_W-1:0] lane_product(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic                  sgn
    );
        logic signed [PROD_W-1:0] ea;
        logic signed [PROD_W-1:0] eb;
        ea = {{(PROD_W-DATA_WIDTH){sgn & a[DATA_WIDTH-1]}}, a};
        eb = {{(PROD_W-DATA_WIDTH){sgn & b[DATA_WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    logic signed [PROD_W-1:0]    prod [NUM_INPUTS];
    logic signed [TREE_W-1:0]    tree [LAYERS+1][NUM_INPUTS];
    logic        [LAYERS:0]      pipe_v;
    logic        [LAYERS:0]      pipe_l;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] result;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            prod[i] = lane_product(i_data_a[i*DATA_WIDTH +: DATA_WIDTH],
                                   i_data_b[i*DATA_WIDTH +: DATA_WIDTH], i_signed);
        end
    end

    // Datapath registers carry no reset; the valid bits decide what is consumed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            tree[0][i] <= TREE_W'(prod[i]);
        end
        for (int l = 1; l <= LAYERS; l++) begin
            for (int j = 0; j < NUM_INPUTS; j++) begin
                if (j < lane_count(l)) begin
                    if (2*j + 1 < lane_count(l-1)) begin
                        tree[l][j] <= tree[l-1][clamp_idx(2*j)] + tree[l-1][clamp_idx(2*j+1)];
                    end else begin
                        tree[l][j] <= tree[l-1][clamp_idx(2*j)];
                    end
                end else begin
                    tree[l][j] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            pipe_l <= '0;
        end else begin
            pipe_v[0] <= i_valid;
            pipe_l[0] <= i_valid & i_last;
            for (int l = 1; l <= LAYERS; l++) begin
                pipe_v[l] <= pipe_v[l-1];
                pipe_l[l] <= pipe_l[l-1];
            end
        end
    end

    always_comb begin
        acc_next = acc + ACC_WIDTH'(tree[LAYERS][0]);
`ifdef MACC_RELU_EN
        result = acc_next[ACC_WIDTH-1] ? '0 : acc_next;
`else
        result = acc_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (pipe_v[LAYERS]) begin
                if (pipe_l[LAYERS]) begin
                    o_data  <= result;
                    o_valid <= 1'b1;
                    acc     <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_macc_acc.sv
// Directed bench for macc_acc (defaults: 9 lanes x int8, 32-bit accumulator).
module tb_macc_acc;

    localparam int N   = 9;
    localparam int D   = 8;
    localparam int LAT = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*D-1:0] i_data_a, i_data_b;
    logic          i_valid, i_last, i_signed;
    logic [31:0]   o_data;
    logic          o_valid;

    macc_acc dut (
        .clk(clk), .rst_n(rst_n),
        .i_data_a(i_data_a), .i_data_b(i_data_b),
        .i_valid(i_valid), .i_last(i_last), .i_signed(i_signed),
        .o_data(o_data), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [31:0] q_data [$];
    int          q_cyc  [$];
    always @(negedge clk) begin
        if (o_valid) begin
            q_data.push_back(o_data);
            q_cyc.push_back(cyc);
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [N*D-1:0] a;
        logic [N*D-1:0] b;
        logic         sgn;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] post(input logic [31:0] v);
`ifdef MACC_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     nm, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic beat(input logic [N*D-1:0] a, input logic [N*D-1:0] b,
                        input logic l, input logic s, output int dc);
        @(negedge clk);
        i_valid  = 1'b1;
        i_last   = l;
        i_signed = s;
        i_data_a = a;
        i_data_b = b;
        dc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid  = 1'b0;
            i_last   = 1'b1;
            i_signed = 1'($urandom_range(1));
            i_data_a = N*D'({$urandom(), $urandom(), $urandom()});
            i_data_b = N*D'({$urandom(), $urandom(), $urandom()});
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic check_single(input string nm, input logic [31:0] exp, input int dc);
        check({nm, "_count"}, q_data.size(), 1);
        if (q_data.size() >= 1) begin
            check({nm, "_data"}, q_data[0], exp);
            check({nm, "_latency"}, q_cyc[0] - dc, LAT);
        end
        check({nm, "_hold"}, o_data, exp);
        check({nm, "_valid_low"}, {31'd0, o_valid}, 32'd0);
    endtask

    logic [N*D-1:0] a_t1, b_t1, a_127, a_neg, b_pos;
    int d0, d1, d2;

    initial begin
        for (int i = 0; i < N; i++) begin
            a_t1[i*D +: D] = D'(i + 1);
            b_t1[i*D +: D] = D'(N - i);
        end
        a_127 = {N{8'h7f}};
        a_neg = {N{8'h80}};
        b_pos = {N{8'h7f}};

        vecs[0] = '{"t1_signed", a_t1, b_t1, 1'b1, 32'd165};
        vecs[1] = '{"ff_unsigned", {N{8'hff}}, {N{8'hff}}, 1'b0, 32'd585225};
        vecs[2] = '{"ff_signed", {N{8'hff}}, {N{8'hff}}, 1'b1, 32'd9};
        vecs[3] = '{"neg_full", a_neg, b_pos, 1'b1, post(-32'sd146304)};
        vecs[4] = '{"lane_idx_signed", {N{8'hff}}, 72'h08_07_06_05_04_03_02_01_00, 1'b1, post(-32'sd36)};
        vecs[5] = '{"lane_idx_unsigned", {N{8'hff}}, 72'h08_07_06_05_04_03_02_01_00, 1'b0, 32'd9180};

        rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_signed = 1'b0;
        i_data_a = '0; i_data_b = '0;
        repeat (3) @(negedge clk);
        check("reset_o_data", o_data, 32'd0);
        check("reset_o_valid", {31'd0, o_valid}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        for (int k = 0; k < 6; k++) begin
            clear_q();
            beat(vecs[k].a, vecs[k].b, 1'b1, vecs[k].sgn, d0);
            idle(10);
            check_single(vecs[k].name, vecs[k].exp, d0);
        end

        // three beats with an idle gap between the first two
        clear_q();
        beat(a_127, a_127, 1'b0, 1'b1, d0);
        idle(1);
        beat(a_127, a_127, 1'b0, 1'b1, d0);
        beat(a_127, a_127, 1'b1, 1'b1, d0);
        idle(10);
        check_single("three_beat_gap", 32'd435483, d0);

        // mode switches between beats of one accumulation
        clear_q();
        beat({N{8'hff}}, {N{8'hff}}, 1'b0, 1'b0, d0);
        beat({N{8'hff}}, {N{8'hff}}, 1'b1, 1'b1, d0);
        idle(10);
        check_single("mode_switch", 32'd585234, d0);

        // back-to-back last beats, then a positive one after the negative
        clear_q();
        beat(a_t1, b_t1, 1'b1, 1'b1, d1);
        beat(a_neg, b_pos, 1'b1, 1'b1, d2);
        beat(a_t1, b_t1, 1'b1, 1'b1, d0);
        idle(10);
        check("b2b_count", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check("b2b_first", q_data[0], 32'd165);
            check("b2b_second", q_data[1], post(-32'sd146304));
            check("b2b_third", q_data[2], 32'd165);
            check("b2b_first_lat", q_cyc[0] - d1, LAT);
            check("b2b_second_lat", q_cyc[1] - d2, LAT);
            check("b2b_third_lat", q_cyc[2] - d0, LAT);
        end

        // idle cycles with i_last high must not start or close anything
        clear_q();
        idle(12);
        check("ignore_invalid_count", q_data.size(), 0);
        beat(a_t1, b_t1, 1'b1, 1'b1, d0);
        idle(10);
        check_single("after_ignore", 32'd165, d0);

        // reset with a partial sum and beats in flight
        clear_q();
        beat(a_127, a_127, 1'b0, 1'b1, d0);
        beat(a_127, a_127, 1'b0, 1'b1, d0);
        @(negedge clk);
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("midreset_o_data", o_data, 32'd0);
        check("midreset_o_valid", {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check("midreset_no_pulse", q_data.size(), 0);
        beat(a_t1, b_t1, 1'b1, 1'b1, d0);
        idle(10);
        check_single("after_midreset", 32'd165, d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
